systolic_seq_ctrl: RTL and testbench
====================================

# systolic_seq_ctrl

Parametrised sequencer for an N×N weight/input systolic array. It counts host operand bytes into the operand memory and generates the skewed per-row and per-column operand selects plus accumulator clear for the MAC array. It then snapshots the N×N accumulator results and streams them to the host as bytes under a valid/ready handshake. Loading of the next operand set may overlap result streaming.

## Interface
Parameters:
- N, 2: array dimension (N ≥ 2).
- DW, 8: host byte/data width.
- ACCW, 16: accumulator width; must be a multiple of DW.
- Derived (localparam): BPE = ACCW/DW; OPS = 2·N·N operand beats; AW = clog2(OPS); SW = clog2(N+1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_en  in  1  host operand beat this cycle (weights first, row-major, then inputs).
- transpose  in  1  input-matrix transpose request; registered to transpose_out.
- c_flat  in  N·N·ACCW  accumulator results, element (i,j) at bits [(i·N+j)·ACCW +: ACCW].
- out_ready  in  1  host accepts out_data.
- mem_addr  out  AW  operand write address for the current load_en beat.
- clear  out  1  accumulator clear.
- data_valid  out  1  array operands valid this cycle.
- a_sel  out  N·SW  row i select at [i·SW +: SW]; value N = bubble (zero operand).
- b_sel  out  N·SW  column j select, same encoding.
- transpose_out  out  1  registered transpose.
- out_data  out  DW  result byte.
- out_valid  out  1  out_data valid.
- out_last  out  1  final byte of result frame.
- done  out  1  one-cycle pulse on final byte handshake.
- busy  out  1  state ≠ IDLE.
- load_err  out  1  sticky: load_en seen in PREP or COMPUTE.

## Operation
- States: IDLE, LOAD, PREP, COMPUTE, OUTPUT.
- Load counter ld_cnt (0..OPS-1) drives mem_addr. It increments on each load_en in IDLE, LOAD or OUTPUT. Reaching OPS-1 with load_en wraps it to 0 and sets ops_ready.
- IDLE: the first load_en moves to LOAD. If that beat is also the final beat (impossible for N ≥ 2), go straight to PREP.
- LOAD → PREP when ops_ready sets.
- PREP, 1 cycle: clear = 1, all selects = N, data_valid = 0; consumes ops_ready.
- COMPUTE, 3N-1 cycles, k = 0..3N-2: data_valid = 1.
  - a_sel[i] = k−i when 0 ≤ k−i < N, else N.
  - b_sel[j] = k−j when 0 ≤ k−j < N, else N.
  - On k = 3N-2, capture c_flat into the result buffer and go to OUTPUT.
- OUTPUT: streams N·N·BPE bytes. Elements go row-major; bytes within an element go MSB first. The byte index advances on out_valid && out_ready. On the final handshake: pulse done, then go to PREP if ops_ready, else IDLE.
- load_en in PREP or COMPUTE: ignored (no address change), sets load_err.
- Selects are registered; the outputs presented in cycle k are the values for cycle k.

## Timing
- Reset values: mem_addr 0, clear 0, data_valid 0, all selects N, transpose_out 0, out_data 0, out_valid 0, out_last 0, done 0, busy 0, load_err 0, state IDLE, ops_ready 0, result buffer 0.
- Reset mid-operation returns to IDLE next edge. Partial loads and streams are discarded.
- Latency, last load beat → clear: 1 cycle. clear → first data_valid: 1 cycle. data_valid length: 3N-1 cycles. Capture edge → out_valid: 1 cycle.
- out_data holds stable while out_valid && !out_ready.
- out_valid deasserts the cycle after the final handshake unless a new frame begins. With back-to-back ops_ready, the gap is PREP + COMPUTE = 3N cycles.
- out_data is 0 whenever out_valid = 0.
- transpose_out lags transpose by 1 cycle in all states.

## Test plan
- N=2 single frame: 8 load_en beats; mem_addr is 0..7; clear pulses once. data_valid is high for 5 cycles. a_sel[0] sequence is 0,1,2,2,2 and a_sel[1] is 2,0,1,2,2. With c_flat = {0x0032,0x002B,0x0016,0x0013}, the stream is 00 13 00 16 00 2B 00 32; out_last and done occur on the 8th byte.
- Backpressure: toggle out_ready 1/0 each cycle → byte order unchanged; each byte held while not ready; done occurs exactly once.
- Overlap: issue 8 load_en beats during OUTPUT → PREP follows the final handshake directly, with no IDLE cycle.
- Illegal load: load_en during COMPUTE → mem_addr unchanged, load_err = 1 until rst.
- Reset mid-OUTPUT after 3 bytes → next cycle out_valid = 0, busy = 0, mem_addr = 0; a new 8-beat load yields a full 8-byte frame.
- N=3, ACCW=24: 18 beats; data_valid is high 8 cycles; a_sel[2] first leaves 3 at k=2; 27 bytes are streamed.

Source files
------------

// File: rtl/systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_seq_ctrl
// Function : Operand-load counter, skewed select generator and result byte
//            streamer for an N x N systolic MAC array.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_seq_ctrl #(
  parameter int N    = 2,
  parameter int DW   = 8,
  parameter int ACCW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic                  transpose,
  input  logic [N*N*ACCW-1:0]   c_flat,
  input  logic                  out_ready,
  output logic [$clog2(2*N*N)-1:0] mem_addr,
  output logic                  clear,
  output logic                  data_valid,
  output logic [N*$clog2(N+1)-1:0] a_sel,
  output logic [N*$clog2(N+1)-1:0] b_sel,
  output logic                  transpose_out,
  output logic [DW-1:0]         out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  done,
  output logic                  busy,
  output logic                  load_err
);

  localparam int BPE  = ACCW / DW;
  localparam int OPS  = 2 * N * N;
  localparam int AW   = $clog2(OPS);
  localparam int SW   = $clog2(N + 1);
  localparam int NE   = N * N;
  localparam int EW   = $clog2(NE);
  localparam int BW   = (BPE > 1) ? $clog2(BPE) : 1;
  localparam int KMAX = 3 * N - 2;
  localparam int KW   = $clog2(3 * N - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_PREP    = 3'd2,
    S_COMPUTE = 3'd3,
    S_OUTPUT  = 3'd4
  } state_t;

  state_t              r_state, w_state_nx;
  logic [AW-1:0]       r_ld_cnt;
  logic                r_ops_ready, w_ops_nx;
  logic [KW-1:0]       r_k, w_k_nx;
  logic [EW-1:0]       r_elem;
  logic [BW-1:0]       r_bsub;
  logic [NE*ACCW-1:0]  r_buf;
  logic                r_clear, r_dv, r_tr, r_err;
  logic [N*SW-1:0]     r_a_sel, r_b_sel, w_sel_nx;
  logic [ACCW-1:0]     w_word;
  logic                w_load_ok, w_load_last, w_hs, w_last_byte, w_capture;

  always_comb begin
    w_load_ok   = load_en && (r_state == S_IDLE || r_state == S_LOAD ||
                              r_state == S_OUTPUT);
    w_load_last = w_load_ok && (r_ld_cnt == AW'(OPS - 1));
    w_last_byte = (r_state == S_OUTPUT) && (r_elem == EW'(NE - 1)) &&
                  (r_bsub == BW'(BPE - 1));
    w_hs        = (r_state == S_OUTPUT) && out_ready;
    w_capture   = (r_state == S_COMPUTE) && (r_k == KW'(KMAX));
  end

  always_comb begin
    w_state_nx = r_state;
    w_k_nx     = r_k;
    w_ops_nx   = r_ops_ready || w_load_last;
    case (r_state)
      S_IDLE:    if (w_load_ok) w_state_nx = w_load_last ? S_PREP : S_LOAD;
      S_LOAD:    if (w_load_last) w_state_nx = S_PREP;
      S_PREP: begin
        w_ops_nx   = 1'b0;
        w_state_nx = S_COMPUTE;
        w_k_nx     = '0;
      end
      S_COMPUTE: begin
        if (w_capture) w_state_nx = S_OUTPUT;
        else           w_k_nx     = r_k + KW'(1);
      end
      S_OUTPUT: begin
        // a load completing on the final handshake still chains straight into PREP
        if (w_hs && w_last_byte) w_state_nx = w_ops_nx ? S_PREP : S_IDLE;
      end
      default:   w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_sel_nx = {N{SW'(N)}};
    if (w_state_nx == S_COMPUTE) begin
      for (int i = 0; i < N; i++) begin
        if (int'(w_k_nx) >= i && int'(w_k_nx) - i < N)
          w_sel_nx[i*SW +: SW] = SW'(int'(w_k_nx) - i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ld_cnt    <= '0;
      r_ops_ready <= 1'b0;
      r_k         <= '0;
      r_elem      <= '0;
      r_bsub      <= '0;
      r_buf       <= '0;
      r_clear     <= 1'b0;
      r_dv        <= 1'b0;
      r_tr        <= 1'b0;
      r_err       <= 1'b0;
      r_a_sel     <= {N{SW'(N)}};
      r_b_sel     <= {N{SW'(N)}};
    end else begin
      r_state     <= w_state_nx;
      r_ops_ready <= w_ops_nx;
      r_k         <= w_k_nx;
      r_clear     <= (w_state_nx == S_PREP);
      r_dv        <= (w_state_nx == S_COMPUTE);
      r_a_sel     <= w_sel_nx;
      r_b_sel     <= w_sel_nx;
      r_tr        <= transpose;
      if (w_load_ok)
        r_ld_cnt <= w_load_last ? '0 : r_ld_cnt + AW'(1);
      if (load_en && (r_state == S_PREP || r_state == S_COMPUTE))
        r_err <= 1'b1;
      if (w_capture) begin
        r_buf  <= c_flat;
        r_elem <= '0;
        r_bsub <= '0;
      end else if (w_hs) begin
        if (r_bsub == BW'(BPE - 1)) begin
          r_bsub <= '0;
          r_elem <= (r_elem == EW'(NE - 1)) ? '0 : r_elem + EW'(1);
        end else begin
          r_bsub <= r_bsub + BW'(1);
        end
      end
    end
  end

  // bytes of each element leave MSB first
  always_comb begin
    w_word   = r_buf[int'(r_elem)*ACCW +: ACCW];
    out_data = '0;
    if (r_state == S_OUTPUT)
      out_data = w_word[(BPE - 1 - int'(r_bsub))*DW +: DW];
  end

  assign mem_addr      = r_ld_cnt;
  assign clear         = r_clear;
  assign data_valid    = r_dv;
  assign a_sel         = r_a_sel;
  assign b_sel         = r_b_sel;
  assign transpose_out = r_tr;
  assign out_valid     = (r_state == S_OUTPUT);
  assign out_last      = w_last_byte;
  assign done          = w_hs && w_last_byte;
  assign busy          = (r_state != S_IDLE);
  assign load_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_seq_ctrl
// Function : Directed self-checking bench for systolic_seq_ctrl (N=2 and N=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0, transpose = 1'b0, out_ready = 1'b0;
  logic [63:0] c_flat = '0;
  logic [2:0]  mem_addr;
  logic [3:0]  a_sel, b_sel;
  logic [7:0]  out_data;
  logic        clear, data_valid, transpose_out, out_valid, out_last, done, busy, load_err;

  logic         load_en3 = 1'b0, out_ready3 = 1'b0;
  logic [215:0] c_flat3 = '0;
  logic [4:0]   mem_addr3;
  logic [5:0]   a_sel3, b_sel3;
  logic [7:0]   out_data3;
  logic         clear3, dv3, tro3, ov3, last3, done3, busy3, err3;

  logic [15:0] vals [4];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  systolic_seq_ctrl #(.N(2), .DW(8), .ACCW(16)) u_dut (
    .clk(clk), .rst(rst), .load_en(load_en), .transpose(transpose),
    .c_flat(c_flat), .out_ready(out_ready), .mem_addr(mem_addr),
    .clear(clear), .data_valid(data_valid), .a_sel(a_sel), .b_sel(b_sel),
    .transpose_out(transpose_out), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .done(done), .busy(busy), .load_err(load_err)
  );

  systolic_seq_ctrl #(.N(3), .DW(8), .ACCW(24)) u_dut3 (
    .clk(clk), .rst(rst), .load_en(load_en3), .transpose(1'b0),
    .c_flat(c_flat3), .out_ready(out_ready3), .mem_addr(mem_addr3),
    .clear(clear3), .data_valid(dv3), .a_sel(a_sel3), .b_sel(b_sel3),
    .transpose_out(tro3), .out_data(out_data3), .out_valid(ov3),
    .out_last(last3), .done(done3), .busy(busy3), .load_err(err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vals(input logic [15:0] v0, v1, v2, v3);
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    c_flat  = {v3, v2, v1, v0};
  endtask

  function automatic logic [7:0] exp_byte(input int idx);
    logic [15:0] v;
    v = vals[idx / 2];
    return (idx % 2 == 0) ? v[15:8] : v[7:0];
  endfunction

  task automatic load_beats(input int n);
    for (int i = 0; i < n; i++) begin
      load_en = 1'b1;
      chk("mem_addr", {29'd0, mem_addr}, i % 8);
      tick();
    end
    load_en = 1'b0;
  endtask

  task automatic wait_ov();
    int c;
    c = 0;
    while (!out_valid && c < 50) begin
      tick();
      c++;
    end
    chk("wait_out_valid", {31'd0, out_valid}, 1);
  endtask

  // receive nb bytes of an 8-byte frame; bp toggles out_ready each cycle
  task automatic recv(input bit bp, input int nb);
    int idx, cyc, nd;
    bit hold;
    logic [7:0] hv;
    idx = 0; cyc = 0; nd = 0; hold = 1'b0; hv = '0;
    while (idx < nb && cyc < 300) begin
      out_ready = bp ? ~cyc[0] : 1'b1;
      #1;
      if (hold) chk("hold", {24'd0, out_data}, {24'd0, hv});
      hold = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          chk("byte", {24'd0, out_data}, {24'd0, exp_byte(idx)});
          chk("last", {31'd0, out_last}, (idx == 7) ? 1 : 0);
          chk("done", {31'd0, done}, (idx == 7) ? 1 : 0);
          if (done) nd++;
          idx++;
        end else begin
          hold = 1'b1;
          hv   = out_data;
        end
      end else begin
        chk("data_zero", {24'd0, out_data}, 0);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready = 1'b0;
    chk("recv_count", idx, nb);
    if (nb == 8) chk("done_count", nd, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dvc, first_k, nbytes, nd3, k3;
    logic [7:0] eb;

    for (int e = 0; e < 9; e++)
      c_flat3[e*24 +: 24] = {8'(e), 8'hA5, 8'(e + 16)};
    set_vals(16'h0013, 16'h0016, 16'h002B, 16'h0032);

    // reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_addr", {29'd0, mem_addr}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_sel", {28'd0, a_sel}, 4'b1010);
    chk("rst_bsel", {28'd0, b_sel}, 4'b1010);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_data", {24'd0, out_data}, 0);
    chk("rst_clear", {31'd0, clear}, 0);
    chk("rst_dv", {31'd0, data_valid}, 0);
    chk("rst_err", {31'd0, load_err}, 0);
    chk("rst_tr", {31'd0, transpose_out}, 0);

    transpose = 1'b1;
    tick();
    transpose = 1'b0;
    #1;
    chk("tr_lag1", {31'd0, transpose_out}, 1);
    tick();
    chk("tr_lag0", {31'd0, transpose_out}, 0);

    // single frame with select sequence
    load_beats(8);
    chk("prep_clear", {31'd0, clear}, 1);
    chk("prep_dv", {31'd0, data_valid}, 0);
    chk("prep_sel", {28'd0, a_sel}, 4'b1010);
    tick();
    begin
      logic [1:0] a0 [5];
      logic [1:0] a1 [5];
      a0 = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2};
      a1 = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd2};
      for (int k = 0; k < 5; k++) begin
        chk("cmp_dv", {31'd0, data_valid}, 1);
        chk("cmp_clear", {31'd0, clear}, 0);
        chk("a_sel0", {30'd0, a_sel[1:0]}, {30'd0, a0[k]});
        chk("a_sel1", {30'd0, a_sel[3:2]}, {30'd0, a1[k]});
        chk("b_sel1", {30'd0, b_sel[3:2]}, {30'd0, a1[k]});
        tick();
      end
    end
    chk("dv_end", {31'd0, data_valid}, 0);
    chk("ov_start", {31'd0, out_valid}, 1);
    recv(1'b0, 8);
    chk("idle_ov", {31'd0, out_valid}, 0);
    chk("idle_busy", {31'd0, busy}, 0);

    // backpressure
    load_beats(8);
    recv(1'b1, 8);

    // overlapped load during OUTPUT
    load_beats(8);
    wait_ov();
    fork
      recv(1'b0, 8);
      load_beats(8);
    join
    chk("ovl_clear", {31'd0, clear}, 1);
    chk("ovl_busy", {31'd0, busy}, 1);
    chk("ovl_ov", {31'd0, out_valid}, 0);
    set_vals(16'h1234, 16'hABCD, 16'h00FF, 16'h8001);
    recv(1'b0, 8);
    chk("ovl_err", {31'd0, load_err}, 0);

    // illegal load during COMPUTE
    load_beats(8);
    tick();
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    chk("ill_addr", {29'd0, mem_addr}, 0);
    chk("ill_err", {31'd0, load_err}, 1);
    recv(1'b0, 8);
    chk("ill_err_sticky", {31'd0, load_err}, 1);

    // reset mid-OUTPUT
    load_beats(8);
    wait_ov();
    fork
      recv(1'b0, 3);
      load_beats(3);
    join
    chk("mid_addr", {29'd0, mem_addr}, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_ov", {31'd0, out_valid}, 0);
    chk("mrst_busy", {31'd0, busy}, 0);
    chk("mrst_addr", {29'd0, mem_addr}, 0);
    chk("mrst_err", {31'd0, load_err}, 0);
    load_beats(8);
    recv(1'b0, 8);

    // N=3, ACCW=24
    out_ready3 = 1'b1;
    for (int i = 0; i < 18; i++) begin
      load_en3 = 1'b1;
      chk("n3_addr", {27'd0, mem_addr3}, i);
      tick();
    end
    load_en3 = 1'b0;
    chk("n3_clear", {31'd0, clear3}, 1);
    dvc = 0; first_k = -1; nbytes = 0; nd3 = 0; k3 = 0;
    for (int c = 0; c < 80 && nd3 == 0; c++) begin
      tick();
      if (dv3) begin
        if (first_k < 0 && a_sel3[5:4] != 2'd3) begin
          first_k = k3;
          chk("n3_asel2_val", {30'd0, a_sel3[5:4]}, 0);
        end
        dvc++;
        k3++;
      end
      if (ov3) begin
        case (nbytes % 3)
          0:       eb = 8'(nbytes / 3);
          1:       eb = 8'hA5;
          default: eb = 8'(nbytes / 3 + 16);
        endcase
        chk("n3_byte", {24'd0, out_data3}, {24'd0, eb});
        chk("n3_last", {31'd0, last3}, (nbytes == 26) ? 1 : 0);
        if (done3) nd3++;
        nbytes++;
      end
    end
    chk("n3_dv_len", dvc, 8);
    chk("n3_first_k", first_k, 2);
    chk("n3_bytes", nbytes, 27);
    chk("n3_done", nd3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
